// File: rtl/pci_arbiter_rr_if.sv
// REQ#/GNT# pairs and the global FRAME#/IRDY# seen by the central arbiter (all active-low).
interface pci_arbiter_rr_if #(
  parameter int N_MASTERS = 8
);
  logic [N_MASTERS-1:0] REQ;
  logic [N_MASTERS-1:0] GNT;
  logic                 FRAME;
  logic                 IRDY;

  modport master (output REQ, output FRAME, output IRDY, input GNT);
  modport slave  (input REQ, input FRAME, input IRDY, output GNT);
endinterface

// File: rtl/pci_arbiter_rr.sv
// Central PCI arbiter: fixed-priority or round-robin, hidden arbitration,
// bus parking and a grant-idle timeout that masks masters that never start.
module pci_arbiter_rr #(
  parameter  int N_MASTERS    = 8,
  parameter  int MODE         = 1,
  parameter  int PARK_MASTER  = 0,
  parameter  int IDLE_TIMEOUT = 16,
  localparam int OW           = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   RST,
  pci_arbiter_rr_if.slave        bus,
  output logic [OW-1:0]          owner,
  output logic                   owner_valid,
  output logic                   timeout_pulse
);

  typedef enum logic [1:0] {S_PARK, S_GRANT, S_BUSY, S_SWITCH} state_t;

  localparam int unsigned   NM       = N_MASTERS;
  localparam logic [OW-1:0] PARK_IDX = OW'(PARK_MASTER);
  localparam logic [7:0]    TO_LAST  = 8'(IDLE_TIMEOUT - 1);

  state_t state, state_d;

  logic [N_MASTERS-1:0] gnt, gnt_d, mask, mask_d, req_eff;
  logic [OW-1:0]        g, g_d, rr_ptr, rr_ptr_d, owner_d, win_idx, target;
  logic [7:0]           cnt, cnt_d;
  logic                 prev_idle, idle, start, fire;
  logic                 win_found, target_park, owner_valid_d, pulse_d;

  assign bus.GNT = gnt;
  assign idle    = bus.FRAME & bus.IRDY;
  assign req_eff = ~bus.REQ & ~mask;

  // A start needs an idle previous cycle and a grant that was already driven.
  assign start = prev_idle & ~bus.FRAME & (state != S_SWITCH);

  always_comb begin
    int unsigned   idx;
    logic [OW-1:0] idx_o;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_o     = '0;
    for (int unsigned k = 0; k < NM; k++) begin
      idx   = (MODE == 0) ? k : ((32'(rr_ptr) + 32'd1 + k) % NM);
      idx_o = OW'(idx);
      if (!win_found && req_eff[idx_o]) begin
        win_found = 1'b1;
        win_idx   = idx_o;
      end
    end
  end

  assign target      = win_found ? win_idx : PARK_IDX;
  assign target_park = ~win_found;
  assign fire        = (state == S_GRANT) & idle & ~target_park & (target == g) & (cnt == TO_LAST);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= S_SWITCH;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_SWITCH: begin
        if (owner_valid && !idle) state_d = S_BUSY;
        else                      state_d = target_park ? S_PARK : S_GRANT;
      end
      S_PARK: begin
        if (start)              state_d = S_BUSY;
        else if (target != g)   state_d = S_SWITCH;
        else if (!target_park)  state_d = S_GRANT;
      end
      S_GRANT: begin
        if (start)              state_d = S_BUSY;
        else if (fire)          state_d = S_SWITCH;
        else if (target != g)   state_d = S_SWITCH;
        else if (target_park)   state_d = S_PARK;
      end
      S_BUSY: begin
        // Hidden arbitration: the grant may move while the owner keeps the bus.
        if (target != g)        state_d = S_SWITCH;
        else if (idle)          state_d = target_park ? S_PARK : S_GRANT;
      end
      default:                  state_d = S_SWITCH;
    endcase
  end

  always_comb begin
    gnt_d = gnt;
    g_d   = g;
    if (state_d == S_SWITCH) begin
      gnt_d = '1;
    end else if (state == S_SWITCH) begin
      gnt_d         = '1;
      gnt_d[target] = 1'b0;
      g_d           = target;
    end

    owner_d       = start ? g : owner;
    rr_ptr_d      = start ? g : rr_ptr;
    owner_valid_d = start ? 1'b1 : (idle ? 1'b0 : owner_valid);
    pulse_d       = fire;

    mask_d = mask & ~bus.REQ;
    if (fire) mask_d[g] = 1'b1;

    if (state == S_GRANT && state_d == S_GRANT) cnt_d = idle ? cnt + 8'd1 : cnt;
    else                                        cnt_d = '0;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      gnt           <= '1;
      g             <= '0;
      owner         <= '0;
      owner_valid   <= 1'b0;
      timeout_pulse <= 1'b0;
      mask          <= '0;
      rr_ptr        <= OW'(N_MASTERS - 1);
      cnt           <= '0;
      prev_idle     <= 1'b1;
    end else begin
      gnt           <= gnt_d;
      g             <= g_d;
      owner         <= owner_d;
      owner_valid   <= owner_valid_d;
      timeout_pulse <= pulse_d;
      mask          <= mask_d;
      rr_ptr        <= rr_ptr_d;
      cnt           <= cnt_d;
      prev_idle     <= idle;
    end
  end

endmodule

// File: tb/tb_pci_arbiter_rr.sv
// Directed bench for pci_arbiter_rr: one round-robin and one fixed-priority instance.
module tb_pci_arbiter_rr;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  pci_arbiter_rr_if #(.N_MASTERS(8)) bus_rr ();
  pci_arbiter_rr_if #(.N_MASTERS(8)) bus_fx ();

  logic [2:0] owner_rr, owner_fx;
  logic       ov_rr, ov_fx, to_rr, to_fx;

  pci_arbiter_rr #(.N_MASTERS(8), .MODE(1), .PARK_MASTER(0), .IDLE_TIMEOUT(16)) dut_rr (
    .clk(clk), .RST(RST), .bus(bus_rr),
    .owner(owner_rr), .owner_valid(ov_rr), .timeout_pulse(to_rr)
  );

  pci_arbiter_rr #(.N_MASTERS(8), .MODE(0), .PARK_MASTER(0), .IDLE_TIMEOUT(16)) dut_fx (
    .clk(clk), .RST(RST), .bus(bus_fx),
    .owner(owner_fx), .owner_valid(ov_fx), .timeout_pulse(to_fx)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] gnt_log[$];
  bit         log_on = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic [7:0] gnt_of(input bit fx);
    return fx ? bus_fx.GNT : bus_rr.GNT;
  endfunction

  function automatic logic [2:0] owner_of(input bit fx);
    return fx ? owner_fx : owner_rr;
  endfunction

  function automatic logic ov_of(input bit fx);
    return fx ? ov_fx : ov_rr;
  endfunction

  task automatic set_bus(input bit fx, input logic v);
    if (fx) begin bus_fx.FRAME = v; bus_fx.IRDY = v; end
    else    begin bus_rr.FRAME = v; bus_rr.IRDY = v; end
  endtask

  task automatic set_req(input bit fx, input logic [7:0] r);
    if (fx) bus_fx.REQ = r;
    else    bus_rr.REQ = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (log_on) gnt_log.push_back(bus_rr.GNT);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    check(e.tag, obs, e.val);
  endtask

  // Master m waits for its grant, runs a 3-cycle transaction, and changes REQ after the start.
  task automatic run_txn(input bit fx, input int unsigned m, input logic [7:0] new_req,
                         input logic [7:0] gnt_end);
    logic [7:0]  want;
    int unsigned n;
    want = ~(8'd1 << m);
    n    = 0;
    while (gnt_of(fx) !== want && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("grant_m%0d", m), gnt_of(fx), want);
    sb.push_back('{$sformatf("owner_m%0d", m), 32'(m)});
    set_bus(fx, 1'b0);
    tick();
    set_req(fx, new_req);
    sb_pop_check(owner_of(fx));
    check("owner_valid_busy", ov_of(fx), 1);
    repeat (2) tick();
    check($sformatf("gnt_end_m%0d", m), gnt_of(fx), gnt_end);
    check($sformatf("owner_hold_m%0d", m), owner_of(fx), m);
    set_bus(fx, 1'b1);
    tick();
    check("owner_valid_idle", ov_of(fx), 0);
  endtask

  initial begin
    int          ff_cnt, run, max_run, direct;
    int unsigned n;

    RST = 1'b0;
    set_req(0, 8'hFF);
    set_req(1, 8'hFF);
    set_bus(0, 1'b1);
    set_bus(1, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    check("reset_gnt_rr", bus_rr.GNT, 8'hFF);
    check("reset_ov_rr", ov_rr, 0);
    RST = 1'b1;
    tick();
    check("park_gnt_rr", bus_rr.GNT, 8'hFE);
    check("park_gnt_fx", bus_fx.GNT, 8'hFE);
    check("park_ov_rr", ov_rr, 0);

    // Round-robin over masters 0..3
    log_on = 1'b1;
    set_req(0, 8'hF0);
    run_txn(0, 0, 8'hF0, 8'hFD);
    run_txn(0, 1, 8'hF0, 8'hFB);
    run_txn(0, 2, 8'hF0, 8'hF7);
    run_txn(0, 3, 8'hF0, 8'hFE);
    run_txn(0, 0, 8'hFF, 8'hFE);
    log_on = 1'b0;

    ff_cnt = 0; run = 0; max_run = 0; direct = 0;
    foreach (gnt_log[i]) begin
      if (gnt_log[i] == 8'hFF) begin
        ff_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        if (run == 0 && i > 0 && gnt_log[i] != gnt_log[i-1]) direct++;
        run = 0;
      end
    end
    check("rr_switch_cycles", ff_cnt, 4);
    check("rr_switch_len", max_run, 1);
    check("rr_direct_moves", direct, 0);

    // Hidden arbitration on the fixed-priority instance
    set_req(1, 8'hFE);
    run_txn(1, 0, 8'hFB, 8'hFB);
    run_txn(1, 2, 8'hFF, 8'hFE);

    // Fixed priority: 0 and 1 before 5 and 7
    set_req(1, 8'h5C);
    run_txn(1, 0, 8'h5D, 8'hFD);
    run_txn(1, 1, 8'h5F, 8'hDF);
    run_txn(1, 5, 8'h7F, 8'h7F);
    run_txn(1, 7, 8'hFF, 8'hFE);

    // Grant-idle timeout for master 3
    set_req(1, 8'hF7);
    n = 0;
    while (bus_fx.GNT !== 8'hF7 && n < 20) begin
      tick();
      n++;
    end
    check("to_grant", bus_fx.GNT, 8'hF7);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("to_pulse_%0d", k), to_fx, (k == 16) ? 1 : 0);
    end
    check("to_release", bus_fx.GNT, 8'hFF);
    tick();
    check("to_park", bus_fx.GNT, 8'hFE);
    check("to_pulse_end", to_fx, 0);
    repeat (2) tick();
    check("to_masked", bus_fx.GNT, 8'hFE);
    set_req(1, 8'hFF);
    tick();
    check("to_unmask_park", bus_fx.GNT, 8'hFE);
    set_req(1, 8'hF7);
    tick();
    check("to_regrant_switch", bus_fx.GNT, 8'hFF);
    tick();
    check("to_regrant", bus_fx.GNT, 8'hF7);

    // Asynchronous reset in the middle of a transaction
    set_req(0, 8'hFD);
    n = 0;
    while (bus_rr.GNT !== 8'hFD && n < 20) begin
      tick();
      n++;
    end
    check("rst_grant", bus_rr.GNT, 8'hFD);
    set_bus(0, 1'b0);
    tick();
    check("rst_busy", ov_rr, 1);
    #2 RST = 1'b0;
    #1;
    check("rst_async_gnt", bus_rr.GNT, 8'hFF);
    check("rst_async_ov", ov_rr, 0);
    check("rst_async_owner", owner_rr, 0);
    check("rst_async_pulse", to_rr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
